// File: rtl/axo_uart_tx_periph_if.sv
// CPU data-bus handshake seen by the console transmitter.
// The CPU side is the master; the peripheral responds through the slave modport.
interface axo_uart_tx_periph_if;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_asize;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_re, mem_we, mem_asize, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_re, mem_we, mem_asize, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/axo_uart_tx_periph.sv
// Memory-mapped console transmitter: CPU writes to DATA are queued in a FIFO
// and sent as 8N1 frames on tx; the CPU is stalled while the FIFO is full.
module axo_uart_tx_periph #(
  parameter logic [31:0] BASE    = 32'h0000_0100,
  parameter int unsigned DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd433
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axo_uart_tx_periph_if.slave        bus,
  output logic                       tx,
  output logic                       busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_DIV, REG_RSVD} reg_e;

  tx_state_e      state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    div_q, div_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     fifo_mem [DEPTH];

  logic       sel;
  reg_e       reg_sel;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       ready;
  logic       wr_en;
  logic       push;
  logic [7:0] wr_byte;
  logic [3:0] lane_en;
  logic [8:0] count_x;

  assign sel        = (bus.mem_addr[31:4] == BASE[31:4]);
  assign reg_sel    = reg_e'(bus.mem_addr[3:2]);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign wr_byte    = bus.mem_wdata[{bus.mem_addr[1:0], 3'b000} +: 8];
  assign count_x    = 9'(count_q);

  // A pop in the same cycle frees a slot, so a full FIFO only stalls when no pop is due.
  assign ready         = !(sel && bus.mem_we && (reg_sel == REG_DATA) && fifo_full && !pop);
  assign bus.mem_ready = ready;
  assign wr_en         = sel && bus.mem_we && ready;
  assign push          = wr_en && (reg_sel == REG_DATA);

  assign busy = !fifo_empty || (state_q != ST_IDLE);

  always_comb begin
    lane_en = 4'b1111;
    case (bus.mem_asize)
      2'd0:    lane_en = 4'b0001 << bus.mem_addr[1:0];
      2'd1:    lane_en = bus.mem_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    div_d    = div_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (wr_en && (reg_sel == REG_DIV)) begin
      if (lane_en[0]) div_d[7:0]  = bus.mem_wdata[7:0];
      if (lane_en[1]) div_d[15:8] = bus.mem_wdata[15:8];
    end
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (sel && bus.mem_re && !bus.mem_we) begin
      case (reg_sel)
        REG_STATUS: bus.mem_rdata = {16'h0, count_x[7:0], 5'b0, busy, fifo_empty, fifo_full};
        REG_DIV:    bus.mem_rdata = {16'h0, div_q};
        default:    bus.mem_rdata = '0;
      endcase
    end
  end

  // The baud counter reloads from DIV at every bit start, so DIV edits land on the next boundary.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = div_q;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_q == '0) begin
          baud_d  = div_q;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = div_q;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) state_d = ST_IDLE;
        else              baud_d  = baud_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      div_q    <= DIV_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_byte;
  end
endmodule

// File: tb/tb_axo_uart_tx_periph.sv
// Self-checking bench: a behavioural UART receiver decodes tx and is compared
// against the bytes the bench wrote, plus cycle-level timing and register checks.
module tb_axo_uart_tx_periph;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  logic busy;

  axo_uart_tx_periph_if bus ();

  axo_uart_tx_periph #(.BASE(BASE), .DEPTH(DEPTH), .DIV_RST(16'd3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receiver model state: bit period taken from the DIV value the bench last programmed.
  int         div_model = 3;
  int         epoch     = 0;
  bit         mon_en    = 1'b0;
  logic [7:0] rx_q [$];
  int         frame_err = 0;
  int         m_p;
  int         m_ep;
  logic [7:0] m_b;
  bit         m_ok;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        m_p  = div_model + 1;
        m_ep = epoch;
        m_b  = '0;
        m_ok = 1'b1;
        repeat (m_p / 2) @(negedge clk);
        if (tx !== 1'b0) m_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (m_p) @(negedge clk);
          m_b[i] = tx;
        end
        repeat (m_p) @(negedge clk);
        if (tx !== 1'b1) m_ok = 1'b0;
        if (m_ep == epoch) begin
          if (m_ok) rx_q.push_back(m_b);
          else      frame_err++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           output int stall);
    @(negedge clk);
    bus.mem_we    = 1'b1;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_asize = sz;
    stall = 0;
    #1;
    while (bus.mem_ready !== 1'b1 && stall < 300) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (stall >= 300) begin
      checks++;
      errors++;
      $display("FAIL write_timeout addr=%h ready stuck low", a);
    end
    @(posedge clk);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_asize = 2'd2;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_asize = 2'd2;
    #1;
    d = bus.mem_rdata;
    bus.mem_re = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy still %b after %0d cycles", busy, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (tx !== 1'b1)            begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.mem_ready); end
    rst_n = 1'b1;
    mon_en = 1'b1;
    bus_read(BASE + 32'h4, rd);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL reset_status got=%h exp=00000002", rd); end
    bus_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL reset_div got=%h exp=00000003", rd); end
    bus_read(BASE + 32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL data_read got=%h exp=0", rd); end
    bus_read(BASE + 32'hC, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_read got=%h exp=0", rd); end
  endtask

  // Cycle-exact frame shape for DIV=3: k counts clocks after the accepting edge.
  task automatic test_single_frame(input logic [7:0] data);
    int         st;
    int         b;
    logic       exp_tx;
    logic       exp_busy;
    logic [31:0] wd;
    rx_q.delete();
    wd = $urandom;
    wd[7:0] = data;
    bus_write(BASE, wd, 2'd0, st);
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1) bus.mem_we = 1'b0;
      #1;
      if (k < 2 || k > 41) exp_tx = 1'b1;
      else begin
        b = (k - 2) / 4;
        if (b == 0)      exp_tx = 1'b0;
        else if (b == 9) exp_tx = 1'b1;
        else             exp_tx = data[b-1];
      end
      exp_busy = (k <= 41);
      checks++; if (tx !== exp_tx)     begin errors++; $display("FAIL frame_tx byte=%h k=%0d got=%b exp=%b", data, k, tx, exp_tx); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL frame_busy byte=%h k=%0d got=%b exp=%b", data, k, busy, exp_busy); end
    end
    bus_idle();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== data) begin
      errors++;
      $display("FAIL frame_rx count=%0d first=%h exp=%h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, data);
    end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL frame_err got=%0d exp=0", frame_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp [6];
    int          st  [6];
    logic [31:0] wd;
    logic [31:0] rd;
    int          lane;
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      exp[i] = 8'($urandom);
      lane   = i % 4;
      wd     = $urandom;
      wd[8*lane +: 8] = exp[i];
      bus_write(BASE + 32'(lane), wd, 2'd0, st[i]);
    end
    bus_idle();
    for (int i = 0; i < 5; i++) begin
      checks++; if (st[i] != 0) begin errors++; $display("FAIL b2b_stall idx=%0d got=%0d exp=0", i, st[i]); end
    end
    checks++; if (st[5] != 37) begin errors++; $display("FAIL b2b_stall idx=5 got=%0d exp=37", st[5]); end
    wait_idle(600);
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte idx=%0d got=%h exp=%h", i, rx_q[i], exp[i]); end
    end
    bus_read(BASE + 32'h4, rd);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL b2b_status got=%h exp=00000002", rd); end
  endtask

  task automatic test_lanes();
    int          st;
    int          n;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  r;
    rx_q.delete();
    wd = {8'($urandom), 8'($urandom), 8'hA7, 8'($urandom)};
    bus_write(BASE + 32'h1, wd, 2'd0, st);
    bus_idle();
    wait_idle(100);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA7) begin
      errors++;
      $display("FAIL lane_rx count=%0d first=%h exp=a7", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    bus_write(BASE + 32'h8, {16'($urandom), 16'h0010}, 2'd1, st);
    bus_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_0010) begin errors++; $display("FAIL div_half got=%h exp=00000010", rd); end
    bus_write(BASE + 32'h9, {16'($urandom), 8'h12, 8'($urandom)}, 2'd0, st);
    bus_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_1210) begin errors++; $display("FAIL div_byte1 got=%h exp=00001210", rd); end
    bus_write(BASE + 32'hA, $urandom, 2'd1, st);
    bus_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_1210) begin errors++; $display("FAIL div_upper_half got=%h exp=00001210", rd); end
    bus_write(BASE + 32'h8, {16'($urandom), 16'h0000}, 2'd2, st);
    bus_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_0000) begin errors++; $display("FAIL div_word got=%h exp=00000000", rd); end
    div_model = 0;
    // DIV=0: one pop cycle plus 10 single-clock bits.
    rx_q.delete();
    r = 8'($urandom);
    bus_write(BASE, {24'h0, r}, 2'd0, st);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.mem_we = 1'b0;
      #1;
      if (busy === 1'b1) n++;
    end
    checks++; if (n != 11) begin errors++; $display("FAIL div0_busy_cycles got=%0d exp=11", n); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== r) begin
      errors++;
      $display("FAIL div0_rx count=%0d first=%h exp=%h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, r);
    end
    bus_write(BASE + 32'h8, 32'h0000_0003, 2'd2, st);
    bus_idle();
    div_model = 3;
  endtask

  task automatic test_reset_mid();
    int          st;
    logic [31:0] rd;
    bit          saw_low;
    bus_write(BASE + 32'h8, 32'h0000_0002, 2'd2, st);
    bus_idle();
    div_model = 2;
    rx_q.delete();
    for (int i = 0; i < 5; i++) bus_write(BASE, $urandom, 2'd0, st);
    bus_read(BASE + 32'h4, rd);
    checks++; if (rd !== 32'h0000_0405) begin errors++; $display("FAIL mid_status_full got=%h exp=00000405", rd); end
    @(negedge clk);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = BASE;
    bus.mem_wdata = $urandom;
    bus.mem_asize = 2'd0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL mid_stall_ready got=%b exp=0", bus.mem_ready); end
    rst_n = 1'b0;
    epoch++;
    @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1)            begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", bus.mem_ready); end
    @(negedge clk);
    rst_n      = 1'b1;
    bus.mem_we = 1'b0;
    div_model  = 3;
    bus_read(BASE + 32'h4, rd);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL mid_rst_status got=%h exp=00000002", rd); end
    bus_read(BASE + 32'h8, rd);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL mid_rst_div got=%h exp=00000003", rd); end
    saw_low = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    checks++; if (saw_low) begin errors++; $display("FAIL mid_rst_quiet got=tx_low exp=tx_high"); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL mid_rst_rx got=%0d exp=0", rx_q.size()); end
  endtask

  task automatic test_outside();
    logic [31:0] a;
    logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      a = BASE + 32'h10;
      else if (i == 1) a = BASE - 32'h4;
      else begin
        a = $urandom;
        if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
      end
      @(negedge clk);
      bus.mem_we    = 1'b1;
      bus.mem_re    = 1'b1;
      bus.mem_addr  = a;
      bus.mem_wdata = $urandom;
      bus.mem_asize = 2'($urandom_range(0, 2));
      #1;
      checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL out_ready addr=%h got=%b exp=1", a, bus.mem_ready); end
      checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL out_rdata addr=%h got=%h exp=0", a, bus.mem_rdata); end
    end
    @(negedge clk);
    bus.mem_we   = 1'b1;
    bus.mem_re   = 1'b1;
    bus.mem_addr = BASE + 32'h4;
    #1;
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL rw_same_cycle got=%h exp=0", bus.mem_rdata); end
    bus_idle();
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL out_busy got=%b exp=0", busy); end
    bus_read(BASE + 32'h4, rd);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL out_status got=%h exp=00000002", rd); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_asize = 2'd2;
    test_reset();
    test_single_frame(8'h55);
    for (int i = 0; i < 3; i++) test_single_frame(8'($urandom));
    test_back_to_back();
    test_lanes();
    test_reset_mid();
    test_outside();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
